// File: rtl/pa_bmu_bus_demux.sv
// pa_bmu_bus_demux
// Routes one upstream bus master (tt_bmu_*) to NPORT downstream slave ports
// by address region, keeping up to DEPTH transactions outstanding.
// Responses must come back in issue order. An in-order FIFO of port IDs
// therefore tracks which port owns the current response (the head). New
// requests may pipeline behind the outstanding ones only when they target
// the same port as the most recent push.
//
// Ports
//   bmu_clk, cpurst_b          clock, async active-low reset
//   tt_bmu_*                   upstream request / attributes / write data
//   bmu_tt_*                   upstream grant, completion, error, read data
//   pad_bmu_port_base/mask     per-port 12-bit region base/mask (addr[31:20])
//   bmu_port_req / _req_dp     one-hot address-phase / data-phase request
//   bmu_port_addr..write       shared copies of the upstream request fields
//   port_bmu_*                 per-port grant, completion, error, read data
//   bmu_tt_clk_en              upstream clock enable (activity indicator)
//   bmu_dbg_cnt/state/proto_err  outstanding count, FSM state, sticky error

// Region decoder for one downstream port.
module pa_bmu_port_dec (
    input  logic [11:0] addr_hi,
    input  logic [11:0] base,
    input  logic [11:0] mask,
    output logic        hit
);
    assign hit = ((addr_hi & mask) == base);
endmodule

module pa_bmu_bus_demux #(
    parameter int NPORT = 4,
    parameter int DEPTH = 2
) (
    input  logic                  bmu_clk,
    input  logic                  cpurst_b,
    // upstream request
    input  logic                  tt_bmu_req,
    input  logic                  tt_bmu_write,
    input  logic                  tt_bmu_data_req,
    input  logic [31:0]           tt_bmu_addr,
    input  logic [31:0]           tt_bmu_wdata,
    input  logic [1:0]            tt_bmu_size,
    input  logic [3:0]            tt_bmu_prot,
    // upstream response
    output logic                  bmu_tt_grant,
    output logic                  bmu_tt_trans_cmplt,
    output logic                  bmu_tt_acc_err,
    output logic [31:0]           bmu_tt_rdata,
    // region map
    input  logic [NPORT*12-1:0]   pad_bmu_port_base,
    input  logic [NPORT*12-1:0]   pad_bmu_port_mask,
    // downstream request
    output logic [NPORT-1:0]      bmu_port_req,
    output logic [NPORT-1:0]      bmu_port_req_dp,
    output logic [31:0]           bmu_port_addr,
    output logic [31:0]           bmu_port_wdata,
    output logic [1:0]            bmu_port_size,
    output logic [3:0]            bmu_port_prot,
    output logic                  bmu_port_write,
    // downstream response
    input  logic [NPORT-1:0]      port_bmu_grnt,
    input  logic [NPORT-1:0]      port_bmu_trans_cmplt,
    input  logic [NPORT-1:0]      port_bmu_acc_err,
    input  logic [NPORT*32-1:0]   port_bmu_data,
    // misc / debug
    output logic                  bmu_tt_clk_en,
    output logic [2:0]            bmu_dbg_cnt,
    output logic [1:0]            bmu_dbg_state,
    output logic                  bmu_dbg_proto_err
);
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [2:0]    CNT_MAX = 3'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    logic [NPORT-1:0]           hit;
    logic [NPORT-1:0][11:0]     base_v;
    logic [NPORT-1:0][11:0]     mask_v;
    logic [NPORT-1:0][31:0]     data_v;

    logic [IW-1:0]              sel;
    logic [DEPTH-1:0][IW-1:0]   fifo_id;
    logic [PW-1:0]              wptr, rptr, wptr_prev;
    logic [IW-1:0]              head_id, last_id;
    logic [2:0]                 cnt, cnt_nxt;
    state_t                     state, state_nxt;
    logic                       err_blk, proto_err;

    logic                       busy, issue_ok, push, pop, stray, head_err;
    logic [NPORT-1:0]           head_oh;

    assign base_v = pad_bmu_port_base;
    assign mask_v = pad_bmu_port_mask;
    assign data_v = port_bmu_data;

    // ------------------------------------------------------------------
    // address decode
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NPORT; g++) begin : g_dec
        pa_bmu_port_dec u_dec (
            .addr_hi (tt_bmu_addr[31:20]),
            .base    (base_v[g]),
            .mask    (mask_v[g]),
            .hit     (hit[g])
        );
    end

    // Lowest-index hit wins; unmapped addresses fall through to the last
    // port, which acts as the default slave.
    always_comb begin
        sel = IW'(NPORT - 1);
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (hit[i]) sel = IW'(i);
        end
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    assign busy      = (cnt != 3'd0);
    assign wptr_prev = (wptr == '0) ? PTR_MAX : wptr - PW'(1);
    assign head_id   = fifo_id[rptr];
    assign last_id   = fifo_id[wptr_prev];
    assign head_oh   = busy ? (NPORT'(1) << head_id) : '0;

    // Pipelining is only safe behind the same port, otherwise responses
    // could return out of order. DRAIN gating also holds off a same-port
    // request that appears while a different-port request is waiting.
    assign issue_ok = tt_bmu_req & (cnt < CNT_MAX) & (~busy | (sel == last_id))
                    & ~err_blk & (state != ST_DRAIN);
    assign push     = issue_ok & port_bmu_grnt[sel];
    assign pop      = |(port_bmu_trans_cmplt & head_oh);
    assign head_err = |(port_bmu_trans_cmplt & port_bmu_acc_err & head_oh);
    // completion from anyone but the head is a slave protocol violation
    assign stray    = |(port_bmu_trans_cmplt & ~head_oh);

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)      cnt_nxt = cnt + 3'd1;
        else if (pop && !push) cnt_nxt = cnt - 3'd1;
    end

    always_ff @(posedge bmu_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            fifo_id   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= 3'd0;
            err_blk   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (push) begin
                fifo_id[wptr] <= sel;
                wptr          <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
            cnt       <= cnt_nxt;
            err_blk   <= head_err;
            proto_err <= proto_err | stray;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge bmu_clk or negedge cpurst_b) begin
        if (!cpurst_b) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (push) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_nxt == 3'd0)                   state_nxt = ST_IDLE;
                else if (tt_bmu_req && sel != last_id) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_nxt == 3'd0)                   state_nxt = ST_IDLE;
                else if (tt_bmu_req && sel == last_id) state_nxt = ST_BUSY;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bmu_port_req       = issue_ok ? (NPORT'(1) << sel) : '0;
    assign bmu_port_req_dp    = tt_bmu_data_req ? head_oh : '0;
    assign bmu_tt_grant       = push;
    assign bmu_tt_trans_cmplt = pop;
    assign bmu_tt_acc_err     = head_err;
    assign bmu_tt_rdata       = busy ? data_v[head_id] : 32'd0;

    assign bmu_port_addr  = tt_bmu_addr;
    assign bmu_port_wdata = tt_bmu_wdata;
    assign bmu_port_size  = tt_bmu_size;
    assign bmu_port_prot  = tt_bmu_prot;
    assign bmu_port_write = tt_bmu_write;

    assign bmu_tt_clk_en     = tt_bmu_req | tt_bmu_data_req | busy;
    assign bmu_dbg_cnt       = cnt;
    assign bmu_dbg_state     = state;
    assign bmu_dbg_proto_err = proto_err;

endmodule

// File: tb/tb_pa_bmu_bus_demux.sv
module tb_pa_bmu_bus_demux;
    localparam int NP = 4;
    localparam int D  = 2;

    logic bmu_clk, cpurst_b;
    logic tt_bmu_req, tt_bmu_write, tt_bmu_data_req;
    logic [31:0] tt_bmu_addr, tt_bmu_wdata;
    logic [1:0]  tt_bmu_size;
    logic [3:0]  tt_bmu_prot;
    logic bmu_tt_grant, bmu_tt_trans_cmplt, bmu_tt_acc_err;
    logic [31:0] bmu_tt_rdata;
    logic [NP*12-1:0] pad_bmu_port_base, pad_bmu_port_mask;
    logic [NP-1:0] bmu_port_req, bmu_port_req_dp;
    logic [31:0] bmu_port_addr, bmu_port_wdata;
    logic [1:0]  bmu_port_size;
    logic [3:0]  bmu_port_prot;
    logic        bmu_port_write;
    logic [NP-1:0] port_bmu_grnt, port_bmu_trans_cmplt, port_bmu_acc_err;
    logic [NP*32-1:0] port_bmu_data;
    logic bmu_tt_clk_en;
    logic [2:0] bmu_dbg_cnt;
    logic [1:0] bmu_dbg_state;
    logic bmu_dbg_proto_err;

    pa_bmu_bus_demux #(.NPORT(NP), .DEPTH(D)) dut (
        .bmu_clk(bmu_clk), .cpurst_b(cpurst_b),
        .tt_bmu_req(tt_bmu_req), .tt_bmu_write(tt_bmu_write),
        .tt_bmu_data_req(tt_bmu_data_req), .tt_bmu_addr(tt_bmu_addr),
        .tt_bmu_wdata(tt_bmu_wdata), .tt_bmu_size(tt_bmu_size),
        .tt_bmu_prot(tt_bmu_prot), .bmu_tt_grant(bmu_tt_grant),
        .bmu_tt_trans_cmplt(bmu_tt_trans_cmplt), .bmu_tt_acc_err(bmu_tt_acc_err),
        .bmu_tt_rdata(bmu_tt_rdata), .pad_bmu_port_base(pad_bmu_port_base),
        .pad_bmu_port_mask(pad_bmu_port_mask), .bmu_port_req(bmu_port_req),
        .bmu_port_req_dp(bmu_port_req_dp), .bmu_port_addr(bmu_port_addr),
        .bmu_port_wdata(bmu_port_wdata), .bmu_port_size(bmu_port_size),
        .bmu_port_prot(bmu_port_prot), .bmu_port_write(bmu_port_write),
        .port_bmu_grnt(port_bmu_grnt), .port_bmu_trans_cmplt(port_bmu_trans_cmplt),
        .port_bmu_acc_err(port_bmu_acc_err), .port_bmu_data(port_bmu_data),
        .bmu_tt_clk_en(bmu_tt_clk_en), .bmu_dbg_cnt(bmu_dbg_cnt),
        .bmu_dbg_state(bmu_dbg_state), .bmu_dbg_proto_err(bmu_dbg_proto_err)
    );

    initial bmu_clk = 1'b0;
    always #5 bmu_clk = ~bmu_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mq[$];          // outstanding port IDs, oldest first
    int mst;            // 0 idle, 1 busy, 2 drain
    bit merrblk, mperr;

    function automatic int sel_of(input logic [31:0] a);
        logic [11:0] b, m;
        for (int i = 0; i < NP; i++) begin
            b = pad_bmu_port_base[i*12 +: 12];
            m = pad_bmu_port_mask[i*12 +: 12];
            if ((a[31:20] & m) == b) return i;
        end
        return NP - 1;
    endfunction

    always @(negedge bmu_clk) begin
        int cnt, hd, lst, s, ncnt;
        bit iss, gnt, pc, ae, stray;
        logic [31:0] erd;
        if (!cpurst_b) begin
            mq.delete(); mst = 0; merrblk = 0; mperr = 0;
            chk("rst_cnt",    32'(bmu_dbg_cnt), 32'd0);
            chk("rst_state",  32'(bmu_dbg_state), 32'd0);
            chk("rst_perr",   32'(bmu_dbg_proto_err), 32'd0);
            chk("rst_dp",     32'(bmu_port_req_dp), 32'd0);
            chk("rst_cmplt",  32'(bmu_tt_trans_cmplt), 32'd0);
            chk("rst_accerr", 32'(bmu_tt_acc_err), 32'd0);
            chk("rst_rdata",  bmu_tt_rdata, 32'd0);
        end else begin
            cnt = mq.size();
            hd  = (cnt > 0) ? mq[0] : 0;
            lst = (cnt > 0) ? mq[cnt-1] : 0;
            s   = sel_of(tt_bmu_addr);
            iss = tt_bmu_req && cnt < D && (cnt == 0 || s == lst) && !merrblk && mst != 2;
            gnt = iss && port_bmu_grnt[s];
            pc  = cnt > 0 && port_bmu_trans_cmplt[hd];
            ae  = pc && port_bmu_acc_err[hd];
            erd = (cnt > 0) ? port_bmu_data[hd*32 +: 32] : 32'd0;
            stray = 0;
            for (int j = 0; j < NP; j++)
                if (port_bmu_trans_cmplt[j] && !(cnt > 0 && j == hd)) stray = 1;

            chk("port_req",  32'(bmu_port_req), iss ? 32'(1 << s) : 32'd0);
            chk("grant",     32'(bmu_tt_grant), 32'(gnt));
            chk("req_dp",    32'(bmu_port_req_dp),
                (cnt > 0 && tt_bmu_data_req) ? 32'(1 << hd) : 32'd0);
            chk("cmplt",     32'(bmu_tt_trans_cmplt), 32'(pc));
            chk("acc_err",   32'(bmu_tt_acc_err), 32'(ae));
            chk("rdata",     bmu_tt_rdata, erd);
            chk("clk_en",    32'(bmu_tt_clk_en),
                32'(tt_bmu_req || tt_bmu_data_req || cnt != 0));
            chk("cnt",       32'(bmu_dbg_cnt), 32'(cnt));
            chk("state",     32'(bmu_dbg_state), 32'(mst));
            chk("proto_err", 32'(bmu_dbg_proto_err), 32'(mperr));
            chk("pass_addr", bmu_port_addr, tt_bmu_addr);
            chk("pass_attr", {bmu_port_wdata[24:0], bmu_port_size, bmu_port_prot, bmu_port_write},
                {tt_bmu_wdata[24:0], tt_bmu_size, tt_bmu_prot, tt_bmu_write});

            // advance
            if (stray) mperr = 1;
            merrblk = ae;
            if (pc)  void'(mq.pop_front());
            if (gnt) mq.push_back(s);
            ncnt = mq.size();
            case (mst)
                0: if (gnt) mst = 1;
                1: if (ncnt == 0) mst = 0;
                   else if (tt_bmu_req && s != lst) mst = 2;
                default: if (ncnt == 0) mst = 0;
                   else if (tt_bmu_req && s == lst) mst = 1;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge bmu_clk); #1;
    endtask

    task automatic clr_in;
        tt_bmu_req = 0; tt_bmu_data_req = 0; tt_bmu_write = 0;
        port_bmu_grnt = '0; port_bmu_trans_cmplt = '0; port_bmu_acc_err = '0;
    endtask

    task automatic go(input logic [31:0] a, input logic [3:0] g);
        tt_bmu_req = 1; tt_bmu_addr = a; port_bmu_grnt = g;
    endtask

    initial begin
        cpurst_b = 0;
        clr_in();
        tt_bmu_addr = 0; tt_bmu_wdata = 0; tt_bmu_size = 0; tt_bmu_prot = 0;
        port_bmu_data = '0;
        // port0 0x000/F00, port1 0x200/F00, port2 0xE00/F00, port3 never hits
        pad_bmu_port_base = {12'h001, 12'hE00, 12'h200, 12'h000};
        pad_bmu_port_mask = {12'h000, 12'hF00, 12'hF00, 12'hF00};
        #2;
        chk("lit_rst_cnt", 32'(bmu_dbg_cnt), 32'd0);
        tick(); tick();
        cpurst_b = 1;

        // single transaction to port 0 with read data
        go(32'h0000_1000, 4'b0001); #2;
        chk("lit_req0", 32'(bmu_port_req), 32'h1);
        chk("lit_gnt0", 32'(bmu_tt_grant), 32'h1);
        tick(); clr_in(); #2;
        chk("lit_cnt1", 32'(bmu_dbg_cnt), 32'd1);
        port_bmu_trans_cmplt = 4'b0001; port_bmu_data[31:0] = 32'hA5A5_A5A5; #1;
        chk("lit_rdata", bmu_tt_rdata, 32'hA5A5_A5A5);
        tick(); clr_in(); #2;
        chk("lit_cnt0", 32'(bmu_dbg_cnt), 32'd0);

        // unmapped address goes to the default port
        go(32'h7000_0000, 4'b0000); #2;
        chk("lit_nohit", 32'(bmu_port_req), 32'h8);
        tick(); clr_in();

        // pipelined same-port issue
        go(32'h2000_0000, 4'b0010); tick(); tick(); #2;
        chk("lit_cnt2", 32'(bmu_dbg_cnt), 32'd2);
        chk("lit_full", 32'(bmu_port_req), 32'h0);
        port_bmu_trans_cmplt = 4'b0010; tick(); #2;
        chk("lit_pp_req", 32'(bmu_port_req), 32'h2);
        tick(); #2;
        chk("lit_pp_cnt", 32'(bmu_dbg_cnt), 32'd1);
        port_bmu_trans_cmplt = 4'b0000; tick(); #2;
        chk("lit_cnt2b", 32'(bmu_dbg_cnt), 32'd2);
        clr_in(); port_bmu_trans_cmplt = 4'b0010; tick(); tick(); clr_in();

        // different port must drain first
        go(32'h0000_0000, 4'b0001); tick();
        go(32'h2000_0000, 4'b0010); tick(); #2;
        chk("lit_drain", 32'(bmu_dbg_state), 32'd2);
        chk("lit_drain_req", 32'(bmu_port_req), 32'h0);
        port_bmu_trans_cmplt = 4'b0001; tick(); port_bmu_trans_cmplt = 4'b0000; #2;
        chk("lit_resume", 32'(bmu_port_req), 32'h2);
        tick(); clr_in(); port_bmu_trans_cmplt = 4'b0010; tick(); clr_in();

        // error completion blocks one cycle; stray completion
        go(32'h0000_0000, 4'b0001); tick(); clr_in();
        port_bmu_trans_cmplt = 4'b0001; port_bmu_acc_err = 4'b0001; #2;
        chk("lit_accerr", 32'(bmu_tt_acc_err), 32'd1);
        tick(); clr_in(); go(32'h0000_0000, 4'b0001); #2;
        chk("lit_errblk", 32'(bmu_port_req), 32'h0);
        tick(); tick(); clr_in();
        port_bmu_trans_cmplt = 4'b1000; tick(); clr_in(); #2;
        chk("lit_perr", 32'(bmu_dbg_proto_err), 32'd1);
        chk("lit_perr_cnt", 32'(bmu_dbg_cnt), 32'd1);
        port_bmu_trans_cmplt = 4'b0001; tick(); clr_in();

        // reset mid-transaction
        go(32'h2000_0000, 4'b0010); tick(); tick(); clr_in(); #2;
        chk("lit_precnt", 32'(bmu_dbg_cnt), 32'd2);
        cpurst_b = 0; #1;
        chk("lit_rcnt", 32'(bmu_dbg_cnt), 32'd0);
        chk("lit_rstate", 32'(bmu_dbg_state), 32'd0);
        chk("lit_rperr", 32'(bmu_dbg_proto_err), 32'd0);
        tick(); cpurst_b = 1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] nib;
            int r;
            r = $urandom_range(0, 4);
            nib = (r == 0) ? 4'h0 : (r == 1) ? 4'h2 : (r == 2) ? 4'hE :
                  (r == 3) ? 4'h7 : 4'($urandom);
            tt_bmu_addr     = {nib, 28'($urandom)};
            tt_bmu_req      = ($urandom_range(0, 9) < 6);
            tt_bmu_data_req = $urandom_range(0, 1) == 1;
            tt_bmu_write    = $urandom_range(0, 1) == 1;
            tt_bmu_wdata    = $urandom;
            tt_bmu_size     = 2'($urandom);
            tt_bmu_prot     = 4'($urandom);
            for (int p = 0; p < NP; p++) begin
                port_bmu_grnt[p]    = ($urandom_range(0, 9) < 7);
                port_bmu_acc_err[p] = ($urandom_range(0, 9) < 2);
                port_bmu_data[p*32 +: 32] = $urandom;
            end
            port_bmu_trans_cmplt = '0;
            if (mq.size() > 0 && $urandom_range(0, 9) < 4)
                port_bmu_trans_cmplt[mq[0]] = 1'b1;
            if ($urandom_range(0, 99) < 2)
                port_bmu_trans_cmplt[$urandom_range(0, NP-1)] = 1'b1;
            if (c == 1500) cpurst_b = 0;
            if (c == 1502) cpurst_b = 1;
            tick();
        end
        clr_in(); tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
